// File: rtl/spi_flash_emu_pkg.sv
// Shared definitions for the SPI flash target emulator.
// Contents: the supported read opcodes, the FSM state and lane-mode enums,
// and small decode helpers used by the top level.
package spi_flash_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_DUAL_READ = 8'h3B;
  localparam logic [7:0] OP_QUAD_READ = 8'h6B;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_e;
  typedef enum logic [1:0] {SINGLE, DUAL, QUAD} lane_e;

  function automatic logic op_supported(logic [7:0] op, logic quad_en);
    return (op == OP_READ) || (op == OP_FAST_READ) || (op == OP_DUAL_READ) ||
           (quad_en && (op == OP_QUAD_READ));
  endfunction

  function automatic lane_e op_lanes(logic [7:0] op);
    case (op)
      OP_DUAL_READ: return DUAL;
      OP_QUAD_READ: return QUAD;
      default:      return SINGLE;
    endcase
  endfunction

  // Pads driven in each mode; single mode answers on io1 (MISO).
  function automatic logic [NUM_LANES-1:0] lane_oe(lane_e m);
    case (m)
      DUAL:    return 4'b0011;
      QUAD:    return 4'b1111;
      default: return 4'b0010;
    endcase
  endfunction

  // Shifts remaining after a byte load: bytes last 8, 4 or 2 SCK periods.
  function automatic logic [2:0] lane_steps(lane_e m);
    case (m)
      DUAL:    return 3'd3;
      QUAD:    return 3'd1;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_emu_if.sv
// Byte-wide memory read port between the emulator (master) and the backing
// store (slave).
//   mem_req   : request, held until mem_ack
//   mem_addr  : byte address, stable while mem_req=1
//   mem_ack   : one-cycle pulse, mem_rdata valid in the same cycle
//   mem_rdata : read byte
interface spi_flash_emu_if #(parameter int ADDR_W = 24) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/spi_flash_emu_sync_edge.sv
// 2-FF synchroniser with rise/fall strobes for an asynchronous level.
//   d    : asynchronous input
//   q    : synchronised level (second flop)
//   rise : one-clk strobe, q went 0->1
//   fall : one-clk strobe, q went 1->0
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  // [0],[1] synchroniser, [2] previous synchronised value
  logic [2:0] pipe;

  always_ff @(posedge clk) begin
    if (!resetn) pipe <= {3{RST_VAL}};
    else         pipe <= {pipe[1:0], d};
  end

  assign q    = pipe[1];
  assign rise =  pipe[1] & ~pipe[2];
  assign fall = ~pipe[1] &  pipe[2];
endmodule

// File: rtl/spi_flash_emu.sv
// SPI flash target emulator. Oversamples SCK/CSn/IO in the clk domain and
// answers 0x03/0x0B/0x3B/0x6B reads in single, dual or quad mode, fetching
// bytes through a one-deep prefetch from the memory port.
//   clk, resetn          : system clock (>= 8x SCK), sync active-low reset
//   spi_sck, spi_csn     : SPI clock (mode 0) and chip select, asynchronous
//   spi_io_i/o/oe        : IO pads; io0 is MOSI for command and address
//   mem                  : memory read port (master side)
//   busy                 : CSn low (synced) or a memory request outstanding
//   err_underrun         : sticky, a byte boundary found no data ready
module spi_flash_emu import spi_flash_pkg::*; #(
  parameter int         ADDR_W        = 24,
  parameter int         DUMMY_CYC     = 8,
  parameter int         QUAD_EN       = 1,
  parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 spi_sck,
  input  logic                 spi_csn,
  input  logic [NUM_LANES-1:0] spi_io_i,
  output logic [NUM_LANES-1:0] spi_io_o,
  output logic [NUM_LANES-1:0] spi_io_oe,
  spi_flash_emu_if.master      mem,
  output logic                 busy,
  output logic                 err_underrun
);
  localparam logic [7:0] ADDR_LAST = 8'(ADDR_W - 1);
  localparam logic [7:0] DUM_LAST  = 8'(DUMMY_CYC - 1);

  logic sck_lvl_unused, sck_rise, sck_fall, csn_s, csn_rise, csn_fall;
  logic unused_io;
  logic [1:0] io0_pipe;
  logic io0, rise_v, fall_v;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck (.clk, .resetn, .d(spi_sck),
    .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_csn (.clk, .resetn, .d(spi_csn),
    .q(csn_s), .rise(csn_rise), .fall(csn_fall));

  // io0 delayed by the same two stages so it lines up with the SCK strobes.
  always_ff @(posedge clk) begin
    if (!resetn) io0_pipe <= '0;
    else         io0_pipe <= {io0_pipe[0], spi_io_i[0]};
  end
  assign io0       = io0_pipe[1];
  assign unused_io = ^spi_io_i[NUM_LANES-1:1];

  // A CSn rise wins over any SCK edge seen in the same cycle.
  assign rise_v = sck_rise & ~csn_rise;
  assign fall_v = sck_fall & ~csn_rise;

  state_e            state, state_n;
  logic [7:0]        cnt;
  logic [ADDR_W-2:0] sh;
  logic [7:0]        op_in, op_q;
  logic [ADDR_W-1:0] addr_in, fa, fa_inc, mem_addr_q;
  lane_e             mode_q;
  logic              mem_req_q, drop_q, need_fetch, pf_valid, err_q;
  logic [7:0]        pf_data, shreg, next_byte;
  logic [2:0]        steps;
  logic [NUM_LANES-1:0] oe_q, io_raw;
  logic              ack_ok, rdy, addr_done, byte_edge, shift_edge;

  assign op_in   = {sh[6:0], io0};
  assign addr_in = {sh, io0};
  assign fa_inc  = fa + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (csn_fall && !mem_req_q) state_n = CMD;
      CMD:   if (sck_rise && cnt == 8'd7)
               state_n = op_supported(op_in, QUAD_EN != 0) ? ADDR : IGNORE;
      ADDR:  if (sck_rise && cnt == ADDR_LAST)
               state_n = (op_q == OP_READ || DUMMY_CYC == 0) ? DATA : DUMMY;
      DUMMY: if (sck_rise && cnt == DUM_LAST) state_n = DATA;
      default: ;
    endcase
    if (csn_rise) state_n = IDLE;
  end

  // A late ack for a byte already replaced by UNDERRUN_BYTE (or for an
  // aborted transaction) is flagged by drop_q and thrown away.
  assign ack_ok     = mem_req_q & mem.mem_ack;
  assign rdy        = pf_valid | (ack_ok & ~drop_q);
  assign next_byte  = pf_valid ? pf_data : mem.mem_rdata;
  assign addr_done  = (state == ADDR) && rise_v && (cnt == ADDR_LAST);
  assign byte_edge  = (state == DATA) && fall_v && (steps == 3'd0);
  assign shift_edge = (state == DATA) && fall_v && (steps != 3'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0; sh <= '0; op_q <= '0; mode_q <= SINGLE; fa <= '0;
      mem_req_q <= 1'b0; mem_addr_q <= '0; drop_q <= 1'b0; need_fetch <= 1'b0;
      pf_valid <= 1'b0; pf_data <= '0; shreg <= '0; steps <= '0;
      oe_q <= '0; err_q <= 1'b0;
    end else begin
      if (state_n != state) cnt <= '0;
      else if (rise_v)      cnt <= cnt + 8'd1;
      if (rise_v && (state == CMD || state == ADDR)) sh <= addr_in[ADDR_W-2:0];
      if (state == CMD && state_n == ADDR) begin
        op_q   <= op_in;
        mode_q <= op_lanes(op_in);
      end

      if (ack_ok) begin
        mem_req_q <= 1'b0;
        drop_q    <= 1'b0;
        if (!drop_q) begin
          pf_valid <= 1'b1;
          pf_data  <= mem.mem_rdata;
        end
      end
      if (need_fetch && !mem_req_q && state == DATA) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= fa;
        need_fetch <= 1'b0;
      end
      if (addr_done) begin
        fa         <= addr_in;
        mem_req_q  <= 1'b1;
        mem_addr_q <= addr_in;
        pf_valid   <= 1'b0;
      end

      if (byte_edge) begin
        shreg    <= rdy ? next_byte : UNDERRUN_BYTE;
        if (!rdy) err_q <= 1'b1;
        pf_valid <= 1'b0;   // an ack landing now went straight into shreg
        fa       <= fa_inc;
        steps    <= lane_steps(mode_q);
        oe_q     <= lane_oe(mode_q);
        if (mem_req_q) begin
          // Still busy (or finishing now): fetch the next byte once free.
          need_fetch <= 1'b1;
          if (!ack_ok) drop_q <= 1'b1;
        end else begin
          mem_req_q  <= 1'b1;
          mem_addr_q <= fa_inc;
        end
      end else if (shift_edge) begin
        steps <= steps - 3'd1;
        case (mode_q)
          DUAL:    shreg <= {shreg[5:0], 2'b00};
          QUAD:    shreg <= {shreg[3:0], 4'b0000};
          default: shreg <= {shreg[6:0], 1'b0};
        endcase
      end

      if (state_n != DATA) oe_q <= '0;
      if (csn_rise) begin
        pf_valid   <= 1'b0;
        need_fetch <= 1'b0;
        steps      <= '0;
        if (mem_req_q && !ack_ok) drop_q <= 1'b1;
      end
    end
  end

  always_comb begin
    io_raw = '0;
    case (mode_q)
      DUAL:    io_raw[1:0] = shreg[7:6];
      QUAD:    io_raw      = shreg[7:4];
      default: io_raw[1]   = shreg[7];
    endcase
  end

  assign spi_io_o     = io_raw & oe_q;
  assign spi_io_oe    = oe_q;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign busy         = ~csn_s | mem_req_q;
  assign err_underrun = err_q;
endmodule

// File: tb/tb_spi_flash_emu.sv
module tb_spi_flash_emu;
  import spi_flash_pkg::*;

  logic       clk = 1'b0, resetn = 1'b0, sck = 1'b0, csn = 1'b1, csn_nq = 1'b1;
  logic [3:0] io_i = 4'h0, io_o, io_oe, io_o_nq, io_oe_nq;
  logic       busy, err, busy_nq, err_nq;
  int         n_cmp = 0, n_bad = 0;

  spi_flash_emu_if #(.ADDR_W(24)) mif ();
  spi_flash_emu_if #(.ADDR_W(24)) mif_nq ();

  spi_flash_emu #(.ADDR_W(24), .DUMMY_CYC(8), .QUAD_EN(1), .UNDERRUN_BYTE(8'hFF)) dut (
    .clk(clk), .resetn(resetn), .spi_sck(sck), .spi_csn(csn), .spi_io_i(io_i),
    .spi_io_o(io_o), .spi_io_oe(io_oe), .mem(mif.master), .busy(busy), .err_underrun(err));

  spi_flash_emu #(.ADDR_W(24), .DUMMY_CYC(8), .QUAD_EN(0), .UNDERRUN_BYTE(8'hFF)) dut_nq (
    .clk(clk), .resetn(resetn), .spi_sck(sck), .spi_csn(csn_nq), .spi_io_i(io_i),
    .spi_io_o(io_o_nq), .spi_io_oe(io_oe_nq), .mem(mif_nq.master), .busy(busy_nq),
    .err_underrun(err_nq));

  always #5 clk = ~clk;

  initial begin
    mif_nq.mem_ack   = 1'b0;
    mif_nq.mem_rdata = 8'h00;
  end

  // Memory model: ack after 'lat' cycles of mem_req, data = addr[7:0]^A5.
  int          lat = 1, wcnt = 0;
  logic [23:0] alog[$];
  always @(negedge clk) begin
    if (mif.mem_ack !== 1'b1 && mif.mem_req === 1'b1) wcnt++;
    else wcnt = 0;
    mif.mem_ack = 1'b0;
    if (wcnt >= lat) begin
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = mif.mem_addr[7:0] ^ 8'hA5;
      alog.push_back(mif.mem_addr);
      wcnt = 0;
    end
  end

  int req_cyc = 0, oe_cyc = 0, nq_req_cyc = 0, nq_oe_cyc = 0;
  always @(negedge clk) begin
    if (mif.mem_req)     req_cyc++;
    if (io_oe != 0)      oe_cyc++;
    if (mif_nq.mem_req)  nq_req_cyc++;
    if (io_oe_nq != 0)   nq_oe_cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sel(input bit nq);
    if (nq) csn_nq = 1'b0; else csn = 1'b0;
    #40;
  endtask

  task automatic desel();
    #40;
    csn = 1'b1; csn_nq = 1'b1;
    repeat (100) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      io_i[0] = v[i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
    io_i[0] = 1'b0;
  endtask

  task automatic dummy(input int n, output bit oe_bad);
    oe_bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      #40 if (io_oe != 0) oe_bad = 1'b1;
      sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  // Samples just before each rising SCK, i.e. 40 ns after the DUT's shift edge.
  task automatic rd_byte(input lane_e m, output logic [7:0] b, output logic [3:0] oe);
    int n;
    n = (m == QUAD) ? 2 : (m == DUAL) ? 4 : 8;
    b = '0;
    oe = '0;
    for (int i = 0; i < n; i++) begin
      #40;
      case (m)
        QUAD:    b = {b[3:0], io_o};
        DUAL:    b = {b[5:0], io_o[1:0]};
        default: b = {b[6:0], io_o[1]};
      endcase
      oe = io_oe;
      sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    lane_e       m;
    int          ndum;
    int          nb;
    logic [31:0] exp;   // byte 0 in [31:24]
    logic [3:0]  oe;
    logic [23:0] a0, a1;
  } vec_t;

  vec_t       tbl[4];
  logic [7:0] b;
  logic [3:0] oe;
  bit         oe_bad;
  int         r0, o0;

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'h03, 24'h030000, SINGLE, 0, 4, 32'hA5A4A7A6, 4'b0010, 24'h030000, 24'h030001};
    tbl[1] = '{8'h3B, 24'h000010, DUAL,   8, 2, 32'hB5B40000, 4'b0011, 24'h000010, 24'h000011};
    tbl[2] = '{8'h6B, 24'h000000, QUAD,   8, 2, 32'hA5A40000, 4'b1111, 24'h000000, 24'h000001};
    tbl[3] = '{8'h0B, 24'hFFFFFF, SINGLE, 8, 2, 32'h5AA50000, 4'b0010, 24'hFFFFFF, 24'h000000};

    repeat (4) @(negedge clk);
    check("rst_oe", io_oe, 0);
    check("rst_io", io_o, 0);
    check("rst_req", mif.mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      alog.delete();
      sel(0);
      send(32'(tbl[v].op), 8);
      send(32'(tbl[v].addr), 24);
      if (tbl[v].ndum > 0) begin
        dummy(tbl[v].ndum, oe_bad);
        check($sformatf("v%0d_dummy_oe", v), 32'(oe_bad), 0);
      end
      for (int k = 0; k < tbl[v].nb; k++) begin
        rd_byte(tbl[v].m, b, oe);
        check($sformatf("v%0d_byte%0d", v, k), b, tbl[v].exp[31-8*k -: 8]);
        check($sformatf("v%0d_oe%0d", v, k), oe, tbl[v].oe);
      end
      desel();
      check($sformatf("v%0d_err", v), err, 0);
      check($sformatf("v%0d_oe_idle", v), io_oe, 0);
      check($sformatf("v%0d_addr0", v), (alog.size() > 0) ? alog[0] : 24'hBADBAD, tbl[v].a0);
      check($sformatf("v%0d_addr1", v), (alog.size() > 1) ? alog[1] : 24'hBADBAD, tbl[v].a1);
    end

    // Unsupported opcode: nothing driven, nothing fetched.
    r0 = req_cyc; o0 = oe_cyc;
    sel(0); send(32'h05, 8); send(32'h123456, 24);
    rd_byte(SINGLE, b, oe);
    desel();
    check("ign_req", 32'(req_cyc - r0), 0);
    check("ign_oe", 32'(oe_cyc - o0), 0);
    sel(0); send(32'h03, 8); send(32'h000042, 24);
    rd_byte(SINGLE, b, oe);
    desel();
    check("post_ign_byte", b, 8'hE7);

    // Quad read on a build without quad support.
    r0 = nq_req_cyc; o0 = nq_oe_cyc;
    sel(1); send(32'h6B, 8); send(32'h000000, 24);
    dummy(8, oe_bad);
    rd_byte(QUAD, b, oe);
    desel();
    check("nq_req", 32'(nq_req_cyc - r0), 0);
    check("nq_oe", 32'(nq_oe_cyc - o0), 0);

    // Slow memory: first byte underruns, flag stays set afterwards.
    lat = 40;
    sel(0); send(32'h03, 8); send(32'h000100, 24);
    rd_byte(SINGLE, b, oe);
    desel();
    check("udr_byte", b, 8'hFF);
    check("udr_err", err, 1);
    lat = 1;
    sel(0); send(32'h03, 8); send(32'h000005, 24);
    rd_byte(SINGLE, b, oe);
    desel();
    check("udr_clean_byte", b, 8'hA0);
    check("udr_sticky", err, 1);

    // CSn raised after 3 data bits with the fetch still outstanding.
    lat = 40;
    sel(0); send(32'h03, 8); send(32'h000200, 24);
    for (int i = 0; i < 3; i++) begin
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
    csn = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_oe", io_oe, 0);
    check("abort_req_held", mif.mem_req, 1);
    check("abort_busy", busy, 1);
    for (int i = 0; i < 100 && mif.mem_req; i++) @(negedge clk);
    check("abort_req_done", mif.mem_req, 0);
    @(negedge clk);
    check("abort_busy_low", busy, 0);
    lat = 1;
    repeat (20) @(negedge clk);
    sel(0); send(32'h03, 8); send(32'h000007, 24);
    rd_byte(SINGLE, b, oe);
    desel();
    check("abort_recover", b, 8'hA2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
